// File: rtl/gpio_serial_loader.sv
// Serial-chain master for a GPIO pad-configuration bank: stores one config word per pad and shifts the
// whole bank out on start, then pulses serial_load. Define GPIO_LOADER_READBACK_EN to add chain readback.
module gpio_serial_loader #(
  parameter int                       NUM_PADS      = 14,
  parameter int                       PAD_CTRL_BITS = 12,
  parameter logic [PAD_CTRL_BITS-1:0] PAD_DEFAULT   = 12'hC00,
  parameter int                       CLK_DIV       = 4
) (
  input  logic                        mclk,
  input  logic                        reset,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(NUM_PADS)-1:0] cfg_wr_addr,
  input  logic [PAD_CTRL_BITS-1:0]    cfg_wr_data,
  input  logic [$clog2(NUM_PADS)-1:0] cfg_rd_addr,
  output logic [PAD_CTRL_BITS-1:0]    cfg_rd_data,
`ifdef GPIO_LOADER_READBACK_EN
  input  logic                        serial_data_ret,
`endif
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        serial_clock,
  output logic                        serial_data,
  output logic                        serial_load
);

  localparam int TB = NUM_PADS * PAD_CTRL_BITS;
  localparam int CW = $clog2(TB + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t                   state;
  logic [DW-1:0]            div;
  logic [CW-1:0]            bit_cnt;
  logic [PAD_CTRL_BITS-1:0] words [NUM_PADS];
  logic [TB-1:0]            flat;
  logic                     wr_ok;
  logic                     first_bit;
  logic                     div_end;

  // Sent bit k is flat[TB-1-k]: pad NUM_PADS-1 MSB first, pad 0 bit 0 last.
  function automatic logic bit_at(input logic [TB-1:0] v, input logic [CW-1:0] cnt);
    int idx;
    idx = TB - 1 - int'(cnt);
    if (idx < 0) return 1'b0;
    return v[idx];
  endfunction

  always_comb begin
    flat = '0;
    for (int p = 0; p < NUM_PADS; p++) flat[p*PAD_CTRL_BITS +: PAD_CTRL_BITS] = words[p];
  end

  assign wr_ok   = cfg_wr_en && !busy && (int'(cfg_wr_addr) < NUM_PADS);
  assign div_end = (div == DW'(CLK_DIV - 1));

  // A write landing in the same cycle as start must already feed the first bit.
  assign first_bit = (wr_ok && int'(cfg_wr_addr) == NUM_PADS - 1) ? cfg_wr_data[PAD_CTRL_BITS-1]
                                                                   : flat[TB-1];

  always_ff @(posedge mclk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PADS; p++) words[p] <= PAD_DEFAULT;
    end else if (wr_ok) begin
      words[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      div          <= '0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            state       <= SHIFT_LO;
            busy        <= 1'b1;
            div         <= '0;
            bit_cnt     <= '0;
            serial_data <= first_bit;
          end
        end
        SHIFT_LO: begin
          if (div_end) begin
            div          <= '0;
            state        <= SHIFT_HI;
            serial_clock <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_end) begin
            div          <= '0;
            bit_cnt      <= bit_cnt + 1'b1;
            serial_clock <= 1'b0;
            if (bit_cnt == CW'(TB - 1)) begin
              state       <= LOAD;
              serial_load <= 1'b1;
              serial_data <= 1'b0;
            end else begin
              state       <= SHIFT_LO;
              serial_data <= bit_at(flat, bit_cnt + 1'b1);
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        LOAD: begin
          if (div_end) begin
            div         <= '0;
            state       <= DONE;
            serial_load <= 1'b0;
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPIO_LOADER_READBACK_EN
  logic [TB-1:0] cap_shift;
  logic [TB-1:0] cap;

  // Sampled on the mclk edge that raises serial_clock, before the chain shifts.
  always_ff @(posedge mclk) begin
    if (state == SHIFT_LO && div_end) cap_shift <= {cap_shift[TB-2:0], serial_data_ret};
  end

  // Committed only when the bank completes, so an aborted transfer leaves cap untouched.
  always_ff @(posedge mclk) begin
    if (reset) cap <= '0;
    else if (state == LOAD && div_end) cap <= cap_shift;
  end

  always_comb begin
    cfg_rd_data = '0;
    if (int'(cfg_rd_addr) < NUM_PADS) cfg_rd_data = cap[int'(cfg_rd_addr)*PAD_CTRL_BITS +: PAD_CTRL_BITS];
  end
`else
  always_comb begin
    cfg_rd_data = '0;
    if (int'(cfg_rd_addr) < NUM_PADS) cfg_rd_data = words[cfg_rd_addr];
  end
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader: default bank plus a CLK_DIV=1, two-pad instance.
module tb_gpio_serial_loader;

  localparam int NP   = 14;
  localparam int PB   = 12;
  localparam int TB   = NP * PB;
  localparam int CD   = 4;
  localparam int LAT  = 1 + TB * 2 * CD + CD;
  localparam int TB2  = 2 * PB;
  localparam int LAT2 = 1 + TB2 * 2 + 1;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic          reset = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [3:0]    cfg_wr_addr = '0;
  logic [PB-1:0] cfg_wr_data = '0;
  logic [3:0]    cfg_rd_addr = '0;
  logic [PB-1:0] cfg_rd_data;
  logic          start = 1'b0;
  logic          busy, done, sc, sd, sl;

  logic          wr_en2 = 1'b0;
  logic          wr_addr2 = 1'b0;
  logic [PB-1:0] wr_data2 = '0;
  logic          rd_addr2 = 1'b0;
  logic [PB-1:0] rd_data2;
  logic          start2 = 1'b0;
  logic          busy2, done2, sc2, sd2, sl2;

  logic [TB-1:0] chain = '0;
  logic [TB-1:0] latched = '0;
  logic [TB-1:0] preload_val = '0;
  logic          preload = 1'b0;

`ifdef GPIO_LOADER_READBACK_EN
  logic ret;
  logic ret2 = 1'b0;
  assign ret = chain[TB-1];
`endif

  gpio_serial_loader dut (
    .mclk(mclk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
`ifdef GPIO_LOADER_READBACK_EN
    .serial_data_ret(ret),
`endif
    .start(start), .busy(busy), .done(done), .serial_clock(sc), .serial_data(sd), .serial_load(sl)
  );

  gpio_serial_loader #(.NUM_PADS(2), .CLK_DIV(1)) dut2 (
    .mclk(mclk), .reset(reset), .cfg_wr_en(wr_en2), .cfg_wr_addr(wr_addr2),
    .cfg_wr_data(wr_data2), .cfg_rd_addr(rd_addr2), .cfg_rd_data(rd_data2),
`ifdef GPIO_LOADER_READBACK_EN
    .serial_data_ret(ret2),
`endif
    .start(start2), .busy(busy2), .done(done2), .serial_clock(sc2), .serial_data(sd2), .serial_load(sl2)
  );

  // Chain model: one long shift register, MSB of pad NP-1 at the far end.
  always @(posedge sc or posedge preload) begin
    if (preload) chain <= preload_val;
    else         chain <= {chain[TB-2:0], sd};
  end
  always @(posedge sl) latched <= chain;

  int            errors = 0;
  int            checks = 0;
  bit            exp_q[$];
  bit            e;
  logic          prev_sc = 1'b0;
  int            load_cnt = 0;
  logic [PB-1:0] mem [NP];
  logic [PB-1:0] pad_def = 12'hC00;

  // Scoreboard: every serial_clock rise pops one expected bit.
  always @(negedge mclk) begin
    if (sc && !prev_sc) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL serial_bit: got %0b but no bit was expected", sd);
      end else begin
        e = exp_q.pop_front();
        if (sd !== e) begin
          errors++;
          $display("FAIL serial_bit: got %0b expected %0b (remaining %0d)", sd, e, exp_q.size());
        end
      end
    end
    if (sl) begin
      load_cnt++;
      checks++;
      if (sc !== 1'b0) begin
        errors++;
        $display("FAIL load_clock_low: serial_clock=%0b during load, expected 0", sc);
      end
    end
    prev_sc <= sc;
  end

  task automatic push_bits();
    for (int p = NP - 1; p >= 0; p--)
      for (int b = PB - 1; b >= 0; b--) exp_q.push_back(mem[p][b]);
  endtask

  function automatic logic [TB-1:0] exp_flat();
    logic [TB-1:0] f;
    for (int p = 0; p < NP; p++) f[p*PB +: PB] = mem[p];
    return f;
  endfunction

  task automatic do_reset();
    @(negedge mclk); reset = 1'b1;
    @(negedge mclk); @(negedge mclk); reset = 1'b0;
    for (int p = 0; p < NP; p++) mem[p] = 12'hC00;
    exp_q.delete();
  endtask

  task automatic write_cfg(input int addr, input logic [PB-1:0] data);
    @(negedge mclk); cfg_wr_en = 1'b1; cfg_wr_addr = 4'(addr); cfg_wr_data = data;
    @(negedge mclk); cfg_wr_en = 1'b0;
    if (addr < NP) mem[addr] = data;
  endtask

  task automatic run_and_wait(output int lat);
    load_cnt = 0;
    @(negedge mclk); start = 1'b1;
    @(negedge mclk); start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LAT + 50) begin
      @(negedge mclk); lat++;
    end
  endtask

  task automatic check_end(input string name, input int lat);
    checks++;
    if (lat != LAT) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
    end
    checks++;
    if (latched !== exp_flat()) begin
      errors++; $display("FAIL %s_chain: got %h expected %h", name, latched, exp_flat());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_bits_left: got %0d expected 0", name, exp_q.size());
    end
    checks++;
    if (load_cnt != CD) begin
      errors++; $display("FAIL %s_load_len: got %0d expected %0d", name, load_cnt, CD);
    end
  endtask

  task automatic test_reset();
    logic [PB-1:0] exp_rd;
    do_reset();
    @(negedge mclk); preload_val = '0; preload = 1'b1;
    @(negedge mclk); preload = 1'b0;
    checks++;
    if ({busy, done, sc, sd, sl} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {busy, done, sc, sd, sl});
    end
`ifdef GPIO_LOADER_READBACK_EN
    exp_rd = '0;
`else
    exp_rd = 12'hC00;
`endif
    for (int a = 0; a < 16; a++) begin
      cfg_rd_addr = 4'(a);
      #1;
      checks++;
      if (cfg_rd_data !== ((a < NP) ? exp_rd : 12'h000)) begin
        errors++; $display("FAIL reset_read[%0d]: got %h expected %h", a, cfg_rd_data,
                           (a < NP) ? exp_rd : 12'h000);
      end
    end
    rd_addr2 = 1'b1;
    #1;
    checks++;
    if (rd_data2 !== exp_rd) begin
      errors++; $display("FAIL reset_read_small: got %h expected %h", rd_data2, exp_rd);
    end
  endtask

  task automatic test_transfer();
    int lat;
    write_cfg(13, 12'hA5A);
    write_cfg(0, 12'h001);
    write_cfg(15, 12'h777);
`ifndef GPIO_LOADER_READBACK_EN
    cfg_rd_addr = 4'd13;
    #1;
    checks++;
    if (cfg_rd_data !== 12'hA5A) begin
      errors++; $display("FAIL write_read13: got %h expected a5a", cfg_rd_data);
    end
`endif
    push_bits();
    run_and_wait(lat);
    check_end("transfer", lat);
    @(negedge mclk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: got done=%0b busy=%0b expected 0 0", done, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    int lat = -1;
    load_cnt = 0;
    push_bits();
    @(negedge mclk); start = 1'b1;
    for (int n = 0; n < LAT + 20; n++) begin
      @(negedge mclk);
      start = (n == 100);
      cfg_wr_en = (n == 200); cfg_wr_addr = 4'd5; cfg_wr_data = 12'hFFF;
      if (done === 1'b1) begin ndone++; lat = n; end
    end
    cfg_wr_en = 1'b0; start = 1'b0;
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL busy_done_count: got %0d expected 1", ndone);
    end
    check_end("busy", lat);
`ifndef GPIO_LOADER_READBACK_EN
    cfg_rd_addr = 4'd5;
    #1;
    checks++;
    if (cfg_rd_data !== 12'hC00) begin
      errors++; $display("FAIL busy_write_ignored: got %h expected c00", cfg_rd_data);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    int lat;
    push_bits();
    @(negedge mclk); start = 1'b1;
    @(negedge mclk); start = 1'b0;
    repeat (50 * 2 * CD + 2) @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk); reset = 1'b0;
    checks++;
    if ({sc, sl, busy, done} !== 4'b0) begin
      errors++; $display("FAIL abort_outputs: got %b expected 0000", {sc, sl, busy, done});
    end
    for (int p = 0; p < NP; p++) mem[p] = 12'hC00;
    exp_q.delete();
    load_cnt = 0;
    repeat (20) begin
      @(negedge mclk);
      if (done === 1'b1 || sl === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || load_cnt != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d done/load cycles expected 0", ndone);
    end
    push_bits();
    run_and_wait(lat);
    check_end("after_abort", lat);
  endtask

  task automatic test_write_with_start();
    int lat;
    push_bits();
    load_cnt = 0;
    @(negedge mclk);
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'd13; cfg_wr_data = 12'h3FF; start = 1'b1;
    mem[13] = 12'h3FF;
    exp_q.delete();
    push_bits();
    @(negedge mclk); cfg_wr_en = 1'b0; start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LAT + 50) begin
      @(negedge mclk); lat++;
    end
    check_end("wr_start", lat);
  endtask

  task automatic test_small();
    int   lat = -1;
    int   rises = 0;
    int   toggles = 0;
    int   ndone = 0;
    logic prev2;
    @(negedge mclk); start2 = 1'b1;
    prev2 = sc2;
    for (int n = 0; n < LAT2 + 10; n++) begin
      @(negedge mclk);
      start2 = 1'b0;
      if (sc2 && !prev2) begin
        checks++;
        if (sd2 !== pad_def[PB - 1 - (rises % PB)]) begin
          errors++; $display("FAIL small_bit[%0d]: got %0b expected %0b", rises, sd2,
                             pad_def[PB - 1 - (rises % PB)]);
        end
        rises++;
      end
      if (n >= 1 && n < 2 * TB2 && sc2 !== prev2) toggles++;
      if (done2 === 1'b1) begin ndone++; if (lat < 0) lat = n; end
      prev2 = sc2;
    end
    checks++;
    if (lat != LAT2 || ndone != 1) begin
      errors++; $display("FAIL small_latency: got %0d (dones %0d) expected %0d", lat, ndone, LAT2);
    end
    checks++;
    if (rises != TB2 || toggles != 2 * TB2 - 1) begin
      errors++; $display("FAIL small_clock: got rises=%0d toggles=%0d expected %0d %0d", rises, toggles,
                         TB2, 2 * TB2 - 1);
    end
  endtask

`ifdef GPIO_LOADER_READBACK_EN
  task automatic test_readback();
    int lat;
    do_reset();
    @(negedge mclk); preload_val = '0; preload_val[7*PB +: PB] = 12'h3C3; preload = 1'b1;
    @(negedge mclk); preload = 1'b0;
    push_bits();
    run_and_wait(lat);
    check_end("readback1", lat);
    cfg_rd_addr = 4'd7;
    #1;
    checks++;
    if (cfg_rd_data !== 12'h3C3) begin
      errors++; $display("FAIL readback_pad7: got %h expected 3c3", cfg_rd_data);
    end
    push_bits();
    run_and_wait(lat);
    check_end("readback2", lat);
    #1;
    checks++;
    if (cfg_rd_data !== 12'hC00) begin
      errors++; $display("FAIL readback_second: got %h expected c00", cfg_rd_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_transfer();
    test_busy_ignore();
    test_reset_abort();
    test_write_with_start();
    test_small();
`ifdef GPIO_LOADER_READBACK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
